// File: rtl/conv_pkg.sv
// Shared helpers for the streaming convolver: ceil-log2, output dimension and
// flattened kernel index.
package conv_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Window positions per dimension; trailing partial positions are dropped.
  function automatic int out_dim(input int n, input int k, input int stride);
    return (n - k) / stride + 1;
  endfunction

  function automatic int widx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One image-row delay line: DEPTH signed samples, shifted only on accepted pixels.
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int DEPTH  = 10,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_ce,
  input  logic signed [DATA_W-1:0] i_din,
  output logic signed [DATA_W-1:0] o_dout
);

  logic signed [DATA_W-1:0] r_taps [DEPTH];

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_taps[i] <= '0;
    end else if (i_ce) begin
      r_taps[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) r_taps[i] <= r_taps[i-1];
    end
  end

  assign o_dout = r_taps[DEPTH-1];

endmodule

// File: rtl/conv_stream.sv
// Streaming KxK signed convolver with stride, per-frame weight latch and
// back-to-back frames. Define CONV_RELU_EN to clamp negative results to zero.
module conv_stream
  import conv_pkg::*;
#(
  parameter int N      = 10,
  parameter int K      = 3,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int STRIDE = 1
) (
  input  logic                     clk,
  input  logic                     global_rst,
  input  logic                     ce,
  input  logic signed [DATA_W-1:0] activation,
  input  logic [K*K*DATA_W-1:0]    weight1,
  output logic signed [ACC_W-1:0]  conv_op,
  output logic                     valid_conv,
  output logic                     end_conv
);

  localparam int CW       = (clog2(N) > 0) ? clog2(N) : 1;
  localparam int OD       = out_dim(N, K, STRIDE);
  localparam int LAST_POS = (K - 1) + (OD - 1) * STRIDE;
  localparam int PW       = 2 * DATA_W;
  localparam int NW       = K * K;
  localparam int NLB      = (K > 1) ? K - 1 : 1;

  logic [CW-1:0]            r_col, r_row;
  logic signed [DATA_W-1:0] r_wgt [NW];
  logic signed [DATA_W-1:0] r_win [K][K];
  logic                     r_win_valid, r_win_last, r_out_last;

  logic signed [DATA_W-1:0] w_row_in [K];
  logic signed [DATA_W-1:0] w_lb_in  [NLB];
  logic signed [DATA_W-1:0] w_lb_out [NLB];
  logic signed [PW-1:0]     w_prod   [NW];
  logic signed [ACC_W-1:0]  w_sum, w_res;
  logic [31:0]              w_col32, w_row32;
  logic                     w_col_ok, w_row_ok, w_win_ok, w_win_last, w_first_px;

  // Raster position of the pixel being offered this cycle.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (ce) begin
      if (r_col == CW'(N - 1)) begin
        r_col <= '0;
        r_row <= (r_row == CW'(N - 1)) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign w_first_px = ce && (r_col == '0) && (r_row == '0);

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      for (int i = 0; i < NW; i++) r_wgt[i] <= '0;
    end else if (w_first_px) begin
      for (int i = 0; i < NW; i++) r_wgt[i] <= weight1[i*DATA_W +: DATA_W];
    end
  end

  // Line buffer chain: buffer gi delays by gi+1 rows; row K-1 is the live pixel.
  genvar gi, gj;
  generate
    for (gi = 0; gi < K - 1; gi++) begin : g_lb
      if (gi == 0) begin : g_head
        assign w_lb_in[gi] = activation;
      end else begin : g_tail
        assign w_lb_in[gi] = w_lb_out[gi-1];
      end
      conv_line_buf #(.DEPTH(N), .DATA_W(DATA_W)) u_line_buf (
        .clk    (clk),
        .i_rst  (global_rst),
        .i_ce   (ce),
        .i_din  (w_lb_in[gi]),
        .o_dout (w_lb_out[gi])
      );
      assign w_row_in[K-2-gi] = w_lb_out[gi];
    end
  endgenerate

  assign w_row_in[K-1] = activation;

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) r_win[r][c] <= '0;
    end else if (ce) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) r_win[r][c] <= r_win[r][c+1];
        r_win[r][K-1] <= w_row_in[r];
      end
    end
  end

  always_comb begin
    w_col32    = 32'(r_col);
    w_row32    = 32'(r_row);
    w_col_ok   = (w_col32 >= 32'(K - 1)) &&
                 (((w_col32 - 32'(K - 1)) % 32'(STRIDE)) == 32'd0);
    w_row_ok   = (w_row32 >= 32'(K - 1)) &&
                 (((w_row32 - 32'(K - 1)) % 32'(STRIDE)) == 32'd0);
    w_win_ok   = w_col_ok && w_row_ok;
    w_win_last = w_win_ok && (w_col32 == 32'(LAST_POS)) && (w_row32 == 32'(LAST_POS));
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
    end else begin
      r_win_valid <= ce && w_win_ok;
      r_win_last  <= ce && w_win_last;
    end
  end

  generate
    for (gi = 0; gi < K; gi++) begin : g_mr
      for (gj = 0; gj < K; gj++) begin : g_mc
        assign w_prod[widx(gi, gj, K)] = PW'(r_win[gi][gj]) * PW'(r_wgt[widx(gi, gj, K)]);
      end
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NW; i++) w_sum = w_sum + ACC_W'(w_prod[i]);
  end

  always_comb begin
`ifdef CONV_RELU_EN
    w_res = w_sum[ACC_W-1] ? '0 : w_sum;
`else
    w_res = w_sum;
`endif
  end

  // Output stage runs regardless of ce so a pending result always drains.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      conv_op    <= '0;
      valid_conv <= 1'b0;
      r_out_last <= 1'b0;
      end_conv   <= 1'b0;
    end else begin
      valid_conv <= r_win_valid;
      r_out_last <= r_win_last;
      end_conv   <= r_out_last;
      if (r_win_valid) conv_op <= w_res;
    end
  end

endmodule
